// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - CSR addresses, op encoding and mstatus field positions for csr_unit
package csr_pkg;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RW   = 2'b01,
        OP_RS   = 2'b10,
        OP_RC   = 2'b11
    } csr_op_t;

    // Machine trap setup / handling
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;

    // Machine counters (writable)
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    // Read-only shadows and identity
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

endpackage

// File: rtl/csr_counter64.sv
// rtl/csr_counter64.sv - split-writable free-running counter used for mcycle and minstret
module csr_counter64 #(
    parameter int CNT_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 wr_lo,
    input  logic                 wr_hi,
    input  logic [CNT_W/2-1:0]   wdata,
    output logic [CNT_W-1:0]     count
);

    // A write to either half wins over the increment; the unwritten half holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (wr_lo || wr_hi) begin
            if (wr_lo) count[CNT_W/2-1:0]     <= wdata;
            if (wr_hi) count[CNT_W-1:CNT_W/2] <= wdata;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/csr_unit.sv
// rtl/csr_unit.sv - machine-mode CSR file with atomic ops, counters and trap/mret updates
module csr_unit
    import csr_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] HART_ID     = '0,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0,
    parameter int              CNT_W       = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            csr_en,
    input  logic [1:0]      csr_op,
    input  logic            src_zero,
    input  logic [11:0]     addr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata,
    output logic            illegal,
    input  logic            retire,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            mret,
    output logic [XLEN-1:0] mtvec_o,
    output logic [XLEN-1:0] mepc_o,
    output logic            mie_o
);

    csr_op_t          op;
    logic             active;
    logic             would_write;
    logic             implemented;
    logic             read_only;
    logic             we;
    logic             csr_we;
    logic [XLEN-1:0]  old_val;
    logic [XLEN-1:0]  new_val;

    logic             mstatus_mie;
    logic             mstatus_mpie;
    logic [XLEN-1:0]  mie_reg;
    logic [XLEN-1:0]  mtvec;
    logic [XLEN-1:0]  mscratch;
    logic [XLEN-1:0]  mepc;
    logic [XLEN-1:0]  mcause;
    logic [XLEN-1:0]  mtval;
    logic [CNT_W-1:0] mcycle;
    logic [CNT_W-1:0] minstret;

    assign op          = csr_op_t'(csr_op);
    assign active      = csr_en && (op != OP_NONE);
    // RS/RC with a zero source is a pure read and may target read-only CSRs.
    assign would_write = (op == OP_RW) || !src_zero;
    assign read_only   = (addr[11:10] == 2'b11);
    assign illegal     = active && (!implemented || (read_only && would_write));
    assign we          = active && !illegal && would_write;
    // Trap and mret take precedence; a colliding CSR write is dropped.
    assign csr_we      = we && !trap_valid && !mret;

    // Sparse read decode; unknown addresses flag as unimplemented.
    always_comb begin
        old_val     = '0;
        implemented = 1'b1;
        case (addr)
            CSR_MSTATUS: begin
                old_val[MSTATUS_MIE]  = mstatus_mie;
                old_val[MSTATUS_MPIE] = mstatus_mpie;
            end
            CSR_MIE:                      old_val = mie_reg;
            CSR_MTVEC:                    old_val = mtvec;
            CSR_MSCRATCH:                 old_val = mscratch;
            CSR_MEPC:                     old_val = mepc;
            CSR_MCAUSE:                   old_val = mcause;
            CSR_MTVAL:                    old_val = mtval;
            CSR_MIP:                      old_val = '0;
            CSR_MCYCLE,   CSR_CYCLE:      old_val = mcycle[CNT_W/2-1:0];
            CSR_MCYCLEH,  CSR_CYCLEH:     old_val = mcycle[CNT_W-1:CNT_W/2];
            CSR_MINSTRET, CSR_INSTRET:    old_val = minstret[CNT_W/2-1:0];
            CSR_MINSTRETH, CSR_INSTRETH:  old_val = minstret[CNT_W-1:CNT_W/2];
            CSR_MHARTID:                  old_val = HART_ID;
            default:                      implemented = 1'b0;
        endcase
    end

    // Atomic read-modify-write value.
    always_comb begin
        new_val = wdata;
        case (op)
            OP_RS:   new_val = old_val | wdata;
            OP_RC:   new_val = old_val & ~wdata;
            default: new_val = wdata;
        endcase
    end

    assign rdata = old_val;

    // Trap entry, mret and CSR writes in priority order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_reg      <= '0;
            mtvec        <= MTVEC_RESET;
            mscratch     <= '0;
            mepc         <= '0;
            mcause       <= '0;
            mtval        <= '0;
        end else if (trap_valid) begin
            mepc         <= trap_pc & ~XLEN'(3);
            mcause       <= trap_cause;
            mtval        <= trap_tval;
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
        end else if (mret) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
        end else if (csr_we) begin
            case (addr)
                CSR_MSTATUS: begin
                    mstatus_mie  <= new_val[MSTATUS_MIE];
                    mstatus_mpie <= new_val[MSTATUS_MPIE];
                end
                CSR_MIE:      mie_reg  <= new_val;
                CSR_MTVEC:    mtvec    <= new_val;
                CSR_MSCRATCH: mscratch <= new_val;
                CSR_MEPC:     mepc     <= new_val & ~XLEN'(3);
                CSR_MCAUSE:   mcause   <= new_val;
                CSR_MTVAL:    mtval    <= new_val;
                default:      ;
            endcase
        end
    end

    csr_counter64 #(.CNT_W(CNT_W)) u_mcycle (
        .clk   (clk),
        .rst   (rst),
        .inc   (1'b1),
        .wr_lo (csr_we && (addr == CSR_MCYCLE)),
        .wr_hi (csr_we && (addr == CSR_MCYCLEH)),
        .wdata (new_val),
        .count (mcycle)
    );

    csr_counter64 #(.CNT_W(CNT_W)) u_minstret (
        .clk   (clk),
        .rst   (rst),
        .inc   (retire),
        .wr_lo (csr_we && (addr == CSR_MINSTRET)),
        .wr_hi (csr_we && (addr == CSR_MINSTRETH)),
        .wdata (new_val),
        .count (minstret)
    );

    assign mtvec_o = mtvec;
    assign mepc_o  = mepc;
    assign mie_o   = mstatus_mie;

endmodule

// File: doc/csr_unit.md
Name: csr_unit

Overview:
- Machine-mode Control and Status Register unit for the RV32 core.
- Replaces the flat 4096-entry array with a sparse set of implemented CSRs.
- Supports RW/RS/RC atomic ops, illegal-access detection, 64-bit cycle/instret counters, and trap-entry/mret state updates.
- Sits beside the controller; the execute stage reads it combinationally and writes it at the clock edge.

Parameters:
XLEN, 32, data width of CSRs and ports (only 32 supported).
HART_ID, 0, value returned by mhartid.
MTVEC_RESET, 32'h0000_0000, reset value of mtvec.
CNT_W, 64, width of mcycle/minstret (64 is the only value that must be supported).

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
csr_en  in  1  CSR instruction in execute this cycle
csr_op  in  2  01=RW, 10=RS, 11=RC, 00=no-op
src_zero  in  1  rs1 is x0 / uimm is 0 (suppresses RS/RC write)
addr  in  12  CSR address
wdata  in  XLEN  operand (rs1 value or zero-extended uimm)
rdata  out  XLEN  old CSR value, combinational
illegal  out  1  access illegal, combinational
retire  in  1  one instruction retired this cycle
trap_valid  in  1  take trap this cycle
trap_cause  in  XLEN  mcause value
trap_pc  in  XLEN  faulting pc
trap_tval  in  XLEN  mtval value
mret  in  1  mret executing this cycle
mtvec_o  out  XLEN  current mtvec
mepc_o  out  XLEN  current mepc
mie_o  out  1  mstatus.MIE

Behaviour:
- Clock port clk; reset port rst, asynchronous and active-high. All registers clear on rst assertion without a clock edge; mtvec resets to MTVEC_RESET. Outputs during reset: rdata and illegal reflect the reset state, mtvec_o=MTVEC_RESET, mepc_o=0, mie_o=0.
- Implemented CSRs:
  - mstatus 0x300: only MIE(bit 3) and MPIE(bit 7) are stored; all other bits read 0.
  - mie 0x304; mtvec 0x305; mscratch 0x340; mtval 0x343.
  - mepc 0x341: bits[1:0] read 0.
  - mcause 0x342.
  - mip 0x344: reads 0, writes ignored.
  - mcycle 0xB00, mcycleh 0xB80, minstret 0xB02, minstreth 0xB82.
  - Read-only: cycle 0xC00, cycleh 0xC80, instret 0xC02, instreth 0xC82, mhartid 0xF14.
- Write value: RW = wdata; RS = old|wdata; RC = old&~wdata.
- Write enable: we = csr_en & op!=00 & !illegal & !(op in {RS,RC} & src_zero). The write occurs at the next posedge.
- illegal = csr_en & op!=00 & (address unimplemented, or addr[11:10]==2'b11 with a would-write access). An RS/RC with src_zero to a read-only CSR is legal. An illegal access changes no state.
- Read latency 0: rdata is the pre-write value in the same cycle.
- Priority within one cycle: trap_valid > mret > CSR write. A lower-priority event in the same cycle is dropped; the controller guarantees it does not retire.
- Trap entry (trap_valid), applied at the next edge:
  - mepc <= trap_pc & ~3.
  - mcause <= trap_cause.
  - mtval <= trap_tval.
  - MPIE <= MIE; MIE <= 0.
- mret: MIE <= MPIE; MPIE <= 1.
- mcycle:
  - Increments by 1 every cycle out of reset and wraps 2^64-1 -> 0.
  - A write to the low or high half in a cycle replaces that half with the written value, and there is no increment that cycle. The other half holds.
- minstret:
  - Same rules as mcycle, but increments only when retire=1.
  - The CSR instruction that writes minstret does not also increment it.
- Carry from bit 31 to bit 32 of both counters is exact on the increment path.

Decomposition:
- Package csr_pkg holds:
  - CSR address localparams.
  - csr_op encoding constants.
  - mstatus bit indices (MIE=3, MPIE=7).
  - a typedef for the op field.
- Sub-module csr_counter64: 64-bit counter with inc, wr_lo, wr_hi and wdata inputs and async reset. It is instantiated twice, for mcycle and minstret.

Test Plan:
- Reset then read: rst pulse; read 0x305 -> MTVEC_RESET; read 0xF14 -> HART_ID; read 0x300 -> 0; mie_o=0.
- Atomic ops:
  - RW 0x340 with 0xA5A5_0000 -> rdata 0.
  - RS with 0x0000_00FF -> rdata 0xA5A5_0000.
  - RC with 0xA500_0000 -> rdata 0xA5A5_00FF.
  - Final read -> 0x00A5_00FF.
- Illegal access:
  - RW to 0xC00 -> illegal=1, counter undisturbed.
  - RS to 0xC00 with src_zero=1 -> illegal=0.
  - Access to 0x7C0 -> illegal=1.
- Trap/mret:
  - Set MIE=1, then trap_valid with pc=0x0000_1236, cause=0x0000_000B.
  - After the edge: mepc=0x1234, mcause=0xB, MIE=0, MPIE=1.
  - mret -> MIE=1, MPIE=1.
  - Trap and CSR write to mscratch in the same cycle -> mscratch unchanged.
- Counter wrap/collision:
  - Write mcycle=0xFFFF_FFFF, then check mcycleh increments on the following cycle.
  - With retire=1 and a write to minstret in the same cycle -> value equals the write value exactly.
- Async reset mid-run: assert rst between clock edges -> all outputs at reset values immediately; counters restart from 0 after release.
